// File: rtl/cmem_bus_arb.sv
// cmem_bus_arb: round-robin line-fill arbiter for NHART cmem instances with
// write-invalidate broadcast and retry of fills made stale by another hart's write.
module cmem_bus_arb #(
    parameter int NHART   = 2,
    parameter int ADDR_W  = 58,
    parameter int LINE_W  = 512,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NHART*ADDR_W-1:0] req_addr,
    input  logic [NHART-1:0]        req_rd,
    output logic [LINE_W-1:0]       req_rdata,
    output logic [NHART-1:0]        req_dv,
    input  logic [NHART*ADDR_W-1:0] wr_addr,
    input  logic [NHART-1:0]        wr_v,
    output logic [NHART-1:0]        wr_stall,
    output logic [ADDR_W-1:0]       inv_addr,
    output logic [NHART-1:0]        inv,
    output logic [ADDR_W-1:0]       m_addr,
    output logic                    m_rd,
    input  logic [LINE_W-1:0]       m_rdata,
    input  logic                    m_dv,
    output logic                    err
);
    localparam int GW = $clog2(NHART);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, BUSY, RETRY, DONE} state_t;
    state_t            state, state_n;
    logic [GW-1:0]     g, g_n, ptr, ptr_n, pick, wsel, cmp_g;
    logic [CW-1:0]     cnt, cnt_n;
    logic              stale, stale_n, m_rd_n, err_n, hit, ld;
    logic [ADDR_W-1:0] m_addr_n, paddr, waddr, cmp_a;
    logic [NHART-1:0]  wlow;

    always_comb begin
        pick = '0;
        for (int i = NHART - 1; i >= 0; i--)
            if (req_rd[(int'(ptr) + 1 + i) % NHART]) pick = GW'((int'(ptr) + 1 + i) % NHART);
        wsel = '0;
        for (int i = NHART - 1; i >= 0; i--)
            if (wr_v[i]) wsel = GW'(i);
    end

    assign wlow     = wr_v & (~wr_v + NHART'(1));
    assign wr_stall = wr_v & ~wlow;
    assign paddr    = req_addr[pick*ADDR_W +: ADDR_W];
    assign waddr    = wr_addr[wsel*ADDR_W +: ADDR_W];
    // in the grant cycle the fill is not registered yet, so compare against the winner
    assign cmp_g    = (state == IDLE) ? pick : g;
    assign cmp_a    = (state == IDLE) ? paddr : m_addr;
    assign hit      = |wr_v && wsel != cmp_g && waddr == cmp_a;

    always_comb begin
        state_n  = state;
        g_n      = g;
        ptr_n    = ptr;
        cnt_n    = cnt;
        stale_n  = stale | hit;
        m_rd_n   = m_rd;
        m_addr_n = m_addr;
        err_n    = err;
        ld       = 1'b0;
        case (state)
            IDLE: if (|req_rd) begin
                g_n      = pick;
                m_addr_n = paddr;
                m_rd_n   = 1'b1;
                stale_n  = hit;
                cnt_n    = '0;
                state_n  = BUSY;
            end
            BUSY: begin
                cnt_n = cnt + CW'(1);
                if (m_dv) begin
                    m_rd_n  = 1'b0;
                    ld      = !(stale | hit);
                    ptr_n   = ld ? g : ptr;
                    state_n = ld ? DONE : RETRY;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    err_n   = 1'b1;
                    m_rd_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            RETRY: begin
                stale_n = hit;
                cnt_n   = '0;
                m_rd_n  = 1'b1;
                state_n = BUSY;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            g         <= '0;
            ptr       <= GW'(NHART - 1);
            cnt       <= '0;
            stale     <= 1'b0;
            m_rd      <= 1'b0;
            m_addr    <= '0;
            err       <= 1'b0;
            req_dv    <= '0;
            req_rdata <= '0;
        end else begin
            state  <= state_n;
            g      <= g_n;
            ptr    <= ptr_n;
            cnt    <= cnt_n;
            stale  <= stale_n;
            m_rd   <= m_rd_n;
            m_addr <= m_addr_n;
            err    <= err_n;
            req_dv <= ld ? (NHART'(1) << g) : '0;
            if (ld) req_rdata <= m_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inv      <= '0;
            inv_addr <= '0;
        end else begin
            inv <= |wr_v ? ~wlow : '0;
            if (|wr_v) inv_addr <= waddr;
        end
    end
endmodule

// File: tb/tb_cmem_bus_arb.sv
// tb_cmem_bus_arb: directed scenarios plus randomized traffic, checked every cycle
// against a transaction-level model of the arbiter.
module tb_cmem_bus_arb;
    localparam int NH = 2, AW = 16, LW = 64, TO = 16;
    logic clk = 0, rst = 1;
    logic [NH*AW-1:0] req_addr, wr_addr;
    logic [NH-1:0]    req_rd, wr_v, req_dv, wr_stall, inv;
    logic [LW-1:0]    req_rdata, m_rdata;
    logic [AW-1:0]    inv_addr, m_addr;
    logic             m_rd, m_dv, err;

    cmem_bus_arb #(.NHART(NH), .ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_addr(req_addr), .req_rd(req_rd), .req_rdata(req_rdata),
        .req_dv(req_dv), .wr_addr(wr_addr), .wr_v(wr_v), .wr_stall(wr_stall),
        .inv_addr(inv_addr), .inv(inv), .m_addr(m_addr), .m_rd(m_rd), .m_rdata(m_rdata),
        .m_dv(m_dv), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    // model: owner of the fill in flight (-1 none), idle gap cycles, last served hart
    int owner, age, gap, last, acc_w;
    bit tainted;
    logic [AW-1:0] faddr, e_inv_addr;
    logic e_m_rd, e_err;
    logic [NH-1:0] e_dv, e_inv, e_stall;
    logic [LW-1:0] e_rdata;
    bit mem_act;
    int mem_lat;
    int seq[4];
    int n;

    task automatic chk(input string nm, input logic [LW-1:0] a, input logic [LW-1:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
        end
    endtask

    function automatic logic [AW-1:0] ra(input int h); return req_addr[h*AW +: AW]; endfunction
    function automatic logic [AW-1:0] wa(input int h); return wr_addr[h*AW +: AW]; endfunction
    function automatic logic [AW-1:0] pool(); return 16'h40 << $urandom_range(0, 3); endfunction

    task automatic model_reset();
        owner = -1; age = 0; gap = 0; last = NH - 1; tainted = 0; faddr = '0; acc_w = -1;
        e_m_rd = 0; e_err = 0; e_dv = '0; e_inv = '0; e_rdata = '0; e_inv_addr = '0; e_stall = '0;
    endtask

    task automatic model_step();
        int chosen, cur;
        bit conflict;
        acc_w = -1;
        for (int h = NH - 1; h >= 0; h--) if (wr_v[h]) acc_w = h;
        e_stall = wr_v;
        if (acc_w >= 0) e_stall[acc_w] = 1'b0;
        chosen = -1;
        if (owner < 0 && gap == 0)
            for (int o = NH; o >= 1; o--) if (req_rd[(last + o) % NH]) chosen = (last + o) % NH;
        cur = (chosen >= 0) ? chosen : owner;
        conflict = acc_w >= 0 && cur >= 0 && acc_w != cur &&
                   wa(acc_w) == ((chosen >= 0) ? ra(chosen) : faddr);
        for (int k = 0; k < NH; k++) e_inv[k] = (acc_w >= 0) && (k != acc_w);
        if (acc_w >= 0) e_inv_addr = wa(acc_w);
        e_dv = '0;
        if (gap > 0) begin
            gap--;
            if (owner >= 0) begin e_m_rd = 1; tainted = conflict; age = 0; end
        end else if (chosen >= 0) begin
            owner = chosen; faddr = ra(chosen); e_m_rd = 1; tainted = conflict; age = 0;
        end else if (owner >= 0) begin
            tainted |= conflict;
            if (m_dv) begin
                e_m_rd = 0; gap = 1;
                if (!tainted) begin e_dv[owner] = 1'b1; e_rdata = m_rdata; last = owner; owner = -1; end
            end else if (age == TO - 1) begin
                e_err = 1; e_m_rd = 0; owner = -1;
            end else age++;
        end
    endtask

    task automatic step();
        #2;
        model_step();
        chk("wr_stall", wr_stall, e_stall);
        @(posedge clk); #1;
        chk("m_rd", m_rd, e_m_rd);
        chk("m_addr", m_addr, faddr);
        chk("req_dv", req_dv, e_dv);
        chk("req_rdata", req_rdata, e_rdata);
        chk("inv", inv, e_inv);
        if (e_inv != 0) chk("inv_addr", inv_addr, e_inv_addr);
        chk("err", err, e_err);
    endtask

    task automatic drive_auto(input int p_req, input int p_wr);
        for (int h = 0; h < NH; h++) begin
            if (e_dv[h]) req_rd[h] = 1'b0;
            else if (!req_rd[h] && $urandom_range(99) < p_req) begin
                req_rd[h] = 1'b1; req_addr[h*AW +: AW] = pool();
            end
            if (h == acc_w) wr_v[h] = 1'b0;
            if (!wr_v[h] && $urandom_range(99) < p_wr) begin
                wr_v[h] = 1'b1; wr_addr[h*AW +: AW] = pool();
            end
        end
        m_dv = 0;
        if (!e_m_rd) begin
            mem_act = 0;
            if ($urandom_range(99) < 3) begin m_dv = 1; m_rdata = {$urandom, $urandom}; end
        end else if (!mem_act) begin
            mem_act = 1;
            mem_lat = ($urandom_range(9) == 0) ? 20 : $urandom_range(4);
        end
        if (mem_act) begin
            if (mem_lat == 0) begin m_dv = 1; m_rdata = {$urandom, $urandom}; mem_act = 0; end
            else mem_lat--;
        end
    endtask

    initial begin
        req_rd = '0; req_addr = '0; wr_v = '0; wr_addr = '0; m_dv = 0; m_rdata = '0;
        mem_act = 0; mem_lat = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_rd", m_rd, 0); chk("rst_m_addr", m_addr, 0); chk("rst_dv", req_dv, 0);
        chk("rst_rdata", req_rdata, 0); chk("rst_inv", inv, 0); chk("rst_inv_addr", inv_addr, 0);
        chk("rst_err", err, 0);
        rst = 0;

        // single request from hart 1
        req_rd = 2'b10; req_addr[AW +: AW] = 'h40; step();
        chk("t1_m_rd", m_rd, 1); chk("t1_m_addr", m_addr, 'h40);
        repeat (4) step();
        m_dv = 1; m_rdata = 64'hdeadbeef01234567; step(); m_dv = 0;
        chk("t1_dv", req_dv, 2'b10); chk("t1_data", req_rdata, 64'hdeadbeef01234567);
        req_rd = '0; step(); chk("t1_pulse", req_dv, 0); step();

        // invalidations
        wr_v = 2'b01; wr_addr[0 +: AW] = 'h80; #1 chk("i1_stall", wr_stall, 0); step();
        chk("i1_inv", inv, 2'b10); chk("i1_addr", inv_addr, 'h80);
        wr_v = 2'b11; wr_addr[0 +: AW] = 'h11; wr_addr[AW +: AW] = 'h22;
        #1 chk("i2_stall", wr_stall, 2'b10); step();
        chk("i2_inv", inv, 2'b10); chk("i2_addr", inv_addr, 'h11);
        wr_v = 2'b10; step(); chk("i3_inv", inv, 2'b01); chk("i3_addr", inv_addr, 'h22);
        wr_v = '0; step(); chk("i4_inv", inv, 0);

        // stale retry
        req_rd = 2'b01; req_addr[0 +: AW] = 'h100; step();
        wr_v = 2'b10; wr_addr[AW +: AW] = 'h100; step(); wr_v = '0; step();
        m_dv = 1; m_rdata = 64'h1111; step(); m_dv = 0;
        chk("s_no_dv", req_dv, 0); chk("s_m_rd_low", m_rd, 0);
        step(); chk("s_reissue", m_rd, 1); chk("s_addr", m_addr, 'h100);
        step(); m_dv = 1; m_rdata = 64'h2222; step(); m_dv = 0;
        chk("s_dv", req_dv, 2'b01); chk("s_data", req_rdata, 64'h2222);
        req_rd = '0; step(); step();

        // timeout
        req_rd = 2'b01; req_addr[0 +: AW] = 'h200; step();
        repeat (15) step();
        chk("to_pre_m_rd", m_rd, 1); chk("to_pre_err", err, 0);
        step(); chk("to_err", err, 1); chk("to_m_rd", m_rd, 0); chk("to_dv", req_dv, 0);
        step(); chk("to_regrant", m_rd, 1); chk("to_regrant_addr", m_addr, 'h200);
        m_dv = 1; m_rdata = 64'h3333; step(); m_dv = 0;
        chk("to_served", req_dv, 2'b01); chk("to_err_sticky", err, 1);
        req_rd = '0; step(); step();

        // asynchronous reset mid-fetch
        req_rd = 2'b10; req_addr[AW +: AW] = 'h300; step(); step();
        #3 rst = 1;
        #1 chk("ar_m_rd", m_rd, 0); chk("ar_err", err, 0); chk("ar_dv", req_dv, 0);
        chk("ar_m_addr", m_addr, 0);
        req_rd = '0;
        @(posedge clk); #1 rst = 0;
        model_reset();
        m_dv = 1; m_rdata = 64'h4444; step(); m_dv = 0;
        chk("ar_late_dv", req_dv, 0); chk("ar_late_m_rd", m_rd, 0);

        // contention: both harts always requesting
        n = 0;
        for (int c = 0; c < 300 && n < 4; c++) begin
            drive_auto(100, 0);
            step();
            if (req_dv != 0) begin seq[n] = int'(req_dv[1]); n++; end
        end
        chk("rr_count", n, 4);
        for (int i = 0; i < 4; i++) chk("rr_order", seq[i], i % 2);

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            drive_auto(30, 35);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
